// File: rtl/ddr3_app_pkg.sv
// Shared command encodings, default widths and the request bundle for the
// DDR3 native-interface request client.
package ddr3_app_pkg;

  localparam int DEF_ADDR_WIDTH   = 28;
  localparam int DEF_DATA_WIDTH   = 256;
  localparam int DEF_MASK_WIDTH   = DEF_DATA_WIDTH / 8;
  localparam int DEF_RD_BUF_DEPTH = 8;

  typedef enum logic [2:0] {
    CMD_WRITE = 3'b000,
    CMD_READ  = 3'b001
  } app_cmd_e;

  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_MASK_WIDTH-1:0] mask;
  } ddr3_app_req_t;

endpackage

// File: rtl/ddr3_rd_fifo.sv
// First-word-fall-through FIFO for read return data. Registered full/empty,
// push accepted while full if a pop happens in the same cycle.
module ddr3_rd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 256
) (
  input  logic             ui_clk,
  input  logic             ui_clk_sync_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             full, do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign head    = mem[rd_ptr];

  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  // NOTE: sequential state uses <= so all registers update from pre-edge values.
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == FULL_COUNT);
    end
  end

  // NOTE: storage has no reset; the empty flag guards it and keeps it RAM-mappable.
  always_ff @(posedge ui_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr3_app_client.sv
// Single-beat request initiator for the DDR3 native app interface: sequences
// app_cmd/app_en and app_wdf_*, and buffers read returns behind read credits.
module ddr3_app_client
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int MASK_WIDTH   = DATA_WIDTH / 8,
  parameter int RD_BUF_DEPTH = DEF_RD_BUF_DEPTH
) (
  input  logic                            ui_clk,
  input  logic                            ui_clk_sync_rst,
  input  logic                            init_calib_complete,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [ADDR_WIDTH-1:0]           req_addr,
  input  logic [DATA_WIDTH-1:0]           req_data,
  input  logic [MASK_WIDTH-1:0]           req_mask,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic [ADDR_WIDTH-1:0]           app_addr,
  output logic [2:0]                      app_cmd,
  output logic                            app_en,
  input  logic                            app_rdy,
  output logic [DATA_WIDTH-1:0]           app_wdf_data,
  output logic [MASK_WIDTH-1:0]           app_wdf_mask,
  output logic                            app_wdf_wren,
  output logic                            app_wdf_end,
  input  logic                            app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]           app_rd_data,
  input  logic                            app_rd_data_valid,
  input  logic                            app_rd_data_end,
  output logic [$clog2(RD_BUF_DEPTH):0]   rd_inflight,
  output logic                            rd_overflow
);

  localparam int CW = $clog2(RD_BUF_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_CREDITS = CW'(RD_BUF_DEPTH);

  logic                  cmd_pend, wd_pend;
  logic                  accept, rd_accept, rsp_pop;
  logic                  fifo_empty, fifo_drop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  unused_rd_end;

  // Every returned beat is a complete response, so the end marker carries nothing.
  assign unused_rd_end = app_rd_data_end;

  assign req_ready = !ui_clk_sync_rst && init_calib_complete &&
                     (!cmd_pend || app_rdy) && (!wd_pend || app_wdf_rdy) &&
                     (rd_inflight < MAX_CREDITS);
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;

  assign app_en       = cmd_pend;
  assign app_wdf_wren = wd_pend;
  assign app_wdf_end  = wd_pend;

  assign rsp_valid = !fifo_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  // Head storage is unreset, so mask it while empty to keep rsp_data clean.
  assign rsp_data  = rsp_valid ? fifo_head : '0;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      cmd_pend     <= 1'b0;
      wd_pend      <= 1'b0;
      app_addr     <= '0;
      app_cmd      <= 3'b000;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      rd_inflight  <= '0;
      rd_overflow  <= 1'b0;
    end else begin
      if (accept) begin
        cmd_pend <= 1'b1;
        app_addr <= req_addr;
        app_cmd  <= req_write ? CMD_WRITE : CMD_READ;
      end else if (app_rdy) begin
        cmd_pend <= 1'b0;
      end

      // Data channel retires on its own handshake, independent of the command.
      if (accept && req_write) begin
        wd_pend      <= 1'b1;
        app_wdf_data <= req_data;
        app_wdf_mask <= req_mask;
      end else if (app_wdf_rdy) begin
        wd_pend <= 1'b0;
      end

      if (rd_accept && !rsp_pop)
        rd_inflight <= rd_inflight + 1'b1;
      else if (!rd_accept && rsp_pop && rd_inflight != '0)
        rd_inflight <= rd_inflight - 1'b1;

      if (fifo_drop) rd_overflow <= 1'b1;
    end
  end

  ddr3_rd_fifo #(
    .DEPTH (RD_BUF_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .ui_clk          (ui_clk),
    .ui_clk_sync_rst (ui_clk_sync_rst),
    .push            (app_rd_data_valid),
    .push_data       (app_rd_data),
    .pop             (rsp_pop),
    .head            (fifo_head),
    .empty           (fifo_empty),
    .drop            (fifo_drop)
  );

endmodule

// File: doc/ddr3_app_client.md
# ddr3_app_client

Request-side initiator for the DDR3 controller's native application interface, clocked in the controller's `ui_clk` domain. It turns a simple valid/ready request stream (single-beat read or write) into correctly sequenced `app_cmd`/`app_en` and `app_wdf_*` transactions. It buffers read return data, which the controller cannot stall, into a credit-protected response FIFO. It sits between LEAP memory-service logic and the DDR3 controller wrapper.

## Interface
- `ADDR_WIDTH`, 28: `app_addr` width.
- `DATA_WIDTH`, 256: one 4:1-mode BL8 burst per command.
- `MASK_WIDTH`, 32: `DATA_WIDTH/8`; a 1 bit masks (does not write) the corresponding byte.
- `RD_BUF_DEPTH`, 8: response FIFO entries. Must be a power of 2, at least 2.
- `ui_clk` in 1: the only clock.
- `ui_clk_sync_rst` in 1: synchronous, active-high reset.
- `init_calib_complete` in 1: no request is accepted while this is low.
- `req_valid` in 1, `req_ready` out 1: request handshake.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH.
- `req_data` in DATA_WIDTH, `req_mask` in MASK_WIDTH: used only for writes.
- `rsp_valid` out 1, `rsp_ready` in 1, `rsp_data` out DATA_WIDTH: read data, returned in request order.
- `app_addr` out ADDR_WIDTH, `app_cmd` out 3, `app_en` out 1, `app_rdy` in 1.
- `app_wdf_data` out DATA_WIDTH, `app_wdf_mask` out MASK_WIDTH, `app_wdf_wren` out 1, `app_wdf_end` out 1, `app_wdf_rdy` in 1.
- `app_rd_data` in DATA_WIDTH, `app_rd_data_valid` in 1, `app_rd_data_end` in 1 (ignored; every beat is a full response).
- `rd_inflight` out clog2(RD_BUF_DEPTH)+1: reserved read credits.
- `rd_overflow` out 1: sticky error flag.

## Operation
- **Acceptance.** `req_ready = init_calib_complete && (!cmd_pend || app_rdy) && (!wd_pend || app_wdf_rdy) && (rd_inflight < RD_BUF_DEPTH)`.
  - `req_ready` does not depend on `req_write`; the credit check is applied to writes as well.
- **Accept (`req_valid && req_ready`).** Register `app_addr` and `app_cmd`, then set `cmd_pend`.
  - Write: `app_cmd = CMD_WRITE` (3'b000). Register data and mask, and set `wd_pend`.
  - Read: `app_cmd = CMD_READ` (3'b001). Increment `rd_inflight`.
- **Command channel.** `app_en = cmd_pend`. It is held with stable addr/cmd until a cycle in which `app_rdy` is 1, then clears unless a new accept occurs in the same cycle.
- **Write-data channel.** `app_wdf_wren = app_wdf_end = wd_pend`. Data and mask are held until `app_wdf_rdy` is 1.
  - The data channel runs independently of the command channel. Either may complete first.
- **Read return.** Each `app_rd_data_valid` beat is pushed into the response FIFO, in order.
  - `rsp_valid` is 1 when the FIFO is non-empty; `rsp_data` is the FIFO head.
  - The head is popped on `rsp_valid && rsp_ready`.
- **Credit counter.** `rd_inflight` increments on a read accept and decrements on a pop. If both happen in the same cycle it is unchanged. It never exceeds `RD_BUF_DEPTH`.
- **Overflow.** If `app_rd_data_valid` arrives while the FIFO is full, the beat is dropped and `rd_overflow` is set. It stays set until reset.
- **Reset.** All pending state is discarded, the FIFO is emptied, and `rd_inflight` is set to 0.
  - Every output resets to 0: `app_en`, `app_wdf_wren`, `app_wdf_end`, `app_cmd`, `app_addr`, `app_wdf_data`, `app_wdf_mask`, `req_ready`, `rsp_valid`, `rsp_data`, `rd_overflow`.

## Timing
- An accept in cycle N drives `app_en` and, for writes, `app_wdf_wren` in cycle N+1.
- With `app_rdy` and `app_wdf_rdy` held high, one request is accepted per cycle.
- Read data with `app_rd_data_valid` in cycle M appears as `rsp_valid` in cycle M+1.
- A pop in cycle K frees a credit visible to `req_ready` in cycle K+1.
- Falling `init_calib_complete` does not abort commands already pending; it only blocks new accepts.

## Structure
- Package `ddr3_app_pkg` holds:
  - `CMD_WRITE` and `CMD_READ`;
  - the default widths;
  - a `ddr3_app_req_t` struct {write, addr, data, mask}.
- Sub-module `ddr3_rd_fifo`: synchronous first-word-fall-through FIFO with depth `RD_BUF_DEPTH`, registered full/empty flags, and push/pop in the same cycle allowed when full.

## Test plan
- **Calibration gate.** Hold `init_calib_complete=0` with `req_valid=1`: `req_ready=0` and `app_en=0` for 10 cycles. Raise calib: the request is accepted in the same cycle and `app_en=1` the next cycle.
- **Write with command stall.** Write addr 0x0000100, data `{8{32'hA5A5_0001}}`, mask 0, with `app_rdy=0` for 3 cycles and `app_wdf_rdy=1`:
  - `app_wdf_wren` is high for exactly 1 cycle;
  - `app_en` is held for 4 cycles with cmd 000;
  - a second request stalls until `app_rdy=1`.
- **Credit exhaustion.** With `RD_BUF_DEPTH=8` and `rsp_ready=0`, issue 9 reads: 8 are accepted and the 9th stalls (`rd_inflight=8`). The model returns 8 beats and no overflow occurs. One pop lets the 9th be accepted in the following cycle.
- **Ordering and simultaneous events.** Reads to addresses 0x10, 0x20 and 0x30 return D0, D1 and D2, which emerge in that order. A pop coinciding with a read accept leaves `rd_inflight` unchanged.
- **Reset mid-operation.** Assert `ui_clk_sync_rst` while `app_en` is pending and 3 entries are buffered: next cycle all outputs are 0 and `rd_inflight=0`.
- **Overflow injection.** Inject a 9th `app_rd_data_valid` beat while the FIFO is full: `rd_overflow=1` and stays set, and the FIFO contents are unchanged.
